// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int D_SIZE        = 32;
  localparam int ADDR_LINE_REG = 5;
  localparam int DRAIN_CYCLES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = pipe_ctrl_pkg::ADDR_LINE_REG
) (
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic          id_uses_rt,
  input  logic          ex_mem_read,
  input  logic [AW-1:0] ex_rd_addr,
  output logic          lu
);

  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign rs_match = (ex_rd_addr == id_rs_addr);
  assign rt_match = id_uses_rt && (ex_rd_addr == id_rt_addr);
  assign lu       = ex_mem_read && (ex_rd_addr != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: start/run/drain/done FSM, hazard and branch controls, perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_LINE_REG = pipe_ctrl_pkg::ADDR_LINE_REG,
  parameter int DRAIN_CYCLES  = pipe_ctrl_pkg::DRAIN_CYCLES,
  parameter int CNT_W         = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic                     opr_finished,
  input  logic [ADDR_LINE_REG-1:0] id_rs_addr,
  input  logic [ADDR_LINE_REG-1:0] id_rt_addr,
  input  logic                     id_uses_rt,
  input  logic                     ex_mem_read,
  input  logic [ADDR_LINE_REG-1:0] ex_rd_addr,
  input  logic                     ex_branch_taken,
  output logic                     pc_en,
  output logic                     if_id_en,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     hazard,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int             DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  pipe_state_t      state_reg;
  pipe_state_t      state_next;
  logic [DRN_W-1:0] drn_reg;
  logic             lu;
  logic             start;

  hazard_detect #(.AW(ADDR_LINE_REG)) u_hazard_detect (
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .lu          (lu)
  );

  assign start = ((state_reg == IDLE) || (state_reg == DONE)) && valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; a taken branch always wins over a load-use stall.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (valid) state_next = RUN;
      RUN:        if (!ex_branch_taken && !lu && opr_finished) state_next = DRAIN;
      DRAIN: begin
        if (ex_branch_taken)                state_next = RUN;
        else if (!lu && drn_reg == DRN_LAST) state_next = DONE;
      end
      default:    state_next = IDLE;
    endcase
  end

  // Pipeline controls; reset forces the idle pattern combinationally as well.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    hazard      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    if (!reset) begin
      case (state_reg)
        RUN, DRAIN: begin
          busy = 1'b1;
          if (ex_branch_taken) begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end else if (lu) begin
            if_id_flush = 1'b0;
            hazard      = 1'b1;
          end else begin
            // In DRAIN the PC freezes and bubbles are loaded behind the last instruction.
            pc_en       = (state_reg == RUN);
            if_id_en    = 1'b1;
            if_id_flush = (state_reg == DRAIN);
            id_ex_flush = 1'b0;
          end
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

  // Drain counter: advances only on clean drain cycles, held during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      drn_reg <= '0;
    end else if (state_reg == DRAIN) begin
      if (!ex_branch_taken && !lu && drn_reg != DRN_LAST) drn_reg <= drn_reg + 1'b1;
    end else begin
      drn_reg <= '0;
    end
  end

  // Saturating performance counters, cleared at each start.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy && (cycle_cnt != '1))   cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Table-driven bench for pipe_ctrl with a scoreboard queue of expected outputs.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic        valid;
  logic        opr_finished;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        ex_branch_taken;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        hazard;
  logic        busy;
  logic        done;
  logic [31:0] cycle_cnt;
  logic [31:0] stall_cnt;

  pipe_ctrl #(.ADDR_LINE_REG(5), .DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid           (valid),
    .opr_finished    (opr_finished),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd_addr      (ex_rd_addr),
    .ex_branch_taken (ex_branch_taken),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .hazard          (hazard),
    .busy            (busy),
    .done            (done),
    .cycle_cnt       (cycle_cnt),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output patterns {pc_en, if_id_en, if_id_flush, id_ex_flush, hazard, busy, done}.
  localparam logic [6:0] IDLE_O  = 7'b0011000;
  localparam logic [6:0] DONE_O  = 7'b0011001;
  localparam logic [6:0] RUN_O   = 7'b1100010;
  localparam logic [6:0] BR_O    = 7'b1111010;
  localparam logic [6:0] LU_O    = 7'b0001110;
  localparam logic [6:0] DRAIN_O = 7'b0110010;

  typedef struct {
    logic       rst, vld, fin, br, mr;
    logic [4:0] rd, rs, rt;
    logic       ut;
    logic [6:0] outs;
    int         cyc, stl;
  } vec_t;

  typedef struct {
    int         idx;
    logic [6:0] outs;
    int         cyc, stl;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic rst, logic vld, logic fin, logic br, logic mr,
                              logic [4:0] rd, logic [4:0] rs, logic [4:0] rt, logic ut,
                              logic [6:0] outs, int cyc, int stl);
    vec_t v;
    v.rst = rst; v.vld = vld; v.fin = fin; v.br = br; v.mr = mr;
    v.rd = rd; v.rs = rs; v.rt = rt; v.ut = ut;
    v.outs = outs; v.cyc = cyc; v.stl = stl;
    return v;
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    @(posedge clk);
    #1;
    reset = v.rst; valid = v.vld; opr_finished = v.fin; ex_branch_taken = v.br;
    ex_mem_read = v.mr; ex_rd_addr = v.rd; id_rs_addr = v.rs; id_rt_addr = v.rt;
    id_uses_rt = v.ut;
    e.idx = idx; e.outs = v.outs; e.cyc = v.cyc; e.stl = v.stl;
    exp_q.push_back(e);
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, if_id_en, if_id_flush, id_ex_flush, hazard, busy, done};
        n_checks += 3;
        if (act !== e.outs) begin
          n_fail++;
          $display("FAIL row%0d ctrl: got %b want %b", e.idx, act, e.outs);
        end
        if (cycle_cnt !== 32'(e.cyc)) begin
          n_fail++;
          $display("FAIL row%0d cycle_cnt: got %0d want %0d", e.idx, cycle_cnt, e.cyc);
        end
        if (stall_cnt !== 32'(e.stl)) begin
          n_fail++;
          $display("FAIL row%0d stall_cnt: got %0d want %0d", e.idx, stall_cnt, e.stl);
        end
        $display("row %0d: ctrl=%b cycle_cnt=%0d stall_cnt=%0d", e.idx, act, cycle_cnt, stall_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; valid = 1'b0; opr_finished = 1'b0; ex_branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_rd_addr = '0; id_rs_addr = '0; id_rt_addr = '0; id_uses_rt = 1'b0;
    repeat (2) @(posedge clk);

    // Reset and idle, then start.
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, IDLE_O, 0, 0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, IDLE_O, 0, 0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, IDLE_O, 0, 0));
    // Five clean cycles, finish, four drain cycles, done.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, RUN_O, i, 0));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,0, RUN_O, 5, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DRAIN_O, 6 + i, 0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DONE_O, 10, 0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DONE_O, 10, 0));
    // Restart; load-use on rt, on rd=0, on rs, rt not read, branch with lu, branch with finish.
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, DONE_O, 10, 0));
    tbl.push_back(mk(0,0,0,0,1, 5,3,5,1, LU_O,   0, 0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, RUN_O,  1, 1));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0,1, RUN_O,  2, 1));
    tbl.push_back(mk(0,0,0,0,1, 7,7,9,0, LU_O,   3, 1));
    tbl.push_back(mk(0,0,0,0,1, 9,1,9,0, RUN_O,  4, 2));
    tbl.push_back(mk(0,0,0,1,1, 5,5,0,0, BR_O,   5, 2));
    tbl.push_back(mk(0,0,1,1,0, 0,0,0,0, BR_O,   6, 2));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, RUN_O,  7, 2));
    // Finish, branch on the third drain cycle, then a full drain.
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,0, RUN_O,   8, 2));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DRAIN_O, 9, 2));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DRAIN_O, 10, 2));
    tbl.push_back(mk(0,0,0,1,0, 0,0,0,0, BR_O,    11, 2));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, RUN_O,   12, 2));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,0, RUN_O,   13, 2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DRAIN_O, 14 + i, 2));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DONE_O, 18, 2));
    // Restart; load-use on drain cycle 2 stretches the drain by one.
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, DONE_O, 18, 2));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,0, RUN_O,   0, 0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DRAIN_O, 1, 0));
    tbl.push_back(mk(0,0,0,0,1, 4,4,0,0, LU_O,    2, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DRAIN_O, 3 + i, 1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, DONE_O, 6, 1));
    // Restart, run seven cycles, then reset for three cycles mid-run.
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, DONE_O, 6, 1));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, RUN_O, i, 0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, IDLE_O, 7, 0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, IDLE_O, 0, 0));
    tbl.push_back(mk(1,1,0,0,0, 0,0,0,0, IDLE_O, 0, 0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, IDLE_O, 0, 0));
    // No hazard reported while idle.
    tbl.push_back(mk(0,0,0,0,1, 5,5,0,0, IDLE_O, 0, 0));

    foreach (tbl[i]) step(tbl[i], i);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_scoreboard: got %0d pending want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer and hazard controller for the 5-stage core (fetch, decode, execute, memory, writeback). It starts the pipeline on `valid` and drives PC/IF-ID enables and IF-ID/ID-EX flushes for load-use stalls and taken branches. On `opr_finished` it drains in-flight instructions and then reports completion. It also keeps cycle and stall performance counters and feeds the `hazard` input of the fetch stage.

## Interface
- `ADDR_LINE_REG`, default 5: register-address width.
- `DRAIN_CYCLES`, default 4: cycles for the last fetched instruction to retire (ID, EX, MEM, WB).
- `CNT_W`, default 32: performance-counter width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  start request; sampled only in IDLE/DONE.
- `opr_finished`  in  1  level; the instruction now in IF is the program's last.
- `id_rs_addr`  in  ADDR_LINE_REG  rs field of the instruction in ID.
- `id_rt_addr`  in  ADDR_LINE_REG  rt field of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads rt.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rd_addr`  in  ADDR_LINE_REG  destination register of the EX instruction.
- `ex_branch_taken`  in  1  branch resolved taken in EX.
- `pc_en`  out  1  PC update enable.
- `if_id_en`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  IF/ID loads a bubble.
- `id_ex_flush`  out  1  ID/EX loads a bubble.
- `hazard`  out  1  load-use stall active this cycle.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.
- `cycle_cnt`  out  CNT_W  busy cycles since the last start.
- `stall_cnt`  out  CNT_W  load-use stall cycles since the last start.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Drain counter `drn`: 0..DRAIN_CYCLES-1.
- Reset values (while `reset` is high and in the cycle after):
  - state IDLE.
  - `pc_en`=0, `if_id_en`=0, `if_id_flush`=1, `id_ex_flush`=1.
  - `hazard`=0, `busy`=0, `done`=0.
  - counters 0.
- `lu` is true when all of the following hold:
  - `ex_mem_read`=1;
  - `ex_rd_addr`≠0;
  - `ex_rd_addr`==`id_rs_addr`, or (`id_uses_rt` and `ex_rd_addr`==`id_rt_addr`).
- Register 0 never hazards.
- IDLE/DONE:
  - Outputs are the reset values, except `done`=1 in DONE.
  - `valid`=1 → RUN. On the same edge, counters clear to 0 and `drn` clears.
- RUN, priority order:
  - (1) `ex_branch_taken`: `pc_en`=1, `if_id_en`=1, `if_id_flush`=1, `id_ex_flush`=1, `hazard`=0. `opr_finished` is ignored (wrong path); stay in RUN.
  - (2) `lu`: `pc_en`=0, `if_id_en`=0, `if_id_flush`=0, `id_ex_flush`=1, `hazard`=1. `opr_finished` is not sampled; stay in RUN.
  - (3) Otherwise: `pc_en`=1, `if_id_en`=1, flushes 0. If `opr_finished`=1 → DRAIN with `drn`=0.
- DRAIN: `pc_en`=0, `if_id_flush`=1 (bubbles enter behind the last instruction).
  - `ex_branch_taken` → back to RUN. Branch outputs apply as in RUN (1), including `pc_en`=1.
  - `lu` → `if_id_en`=0, `if_id_flush`=0, `id_ex_flush`=1, `hazard`=1; `drn` holds.
  - Otherwise `drn` increments. At `drn`==DRAIN_CYCLES-1 with no `lu` → DONE.
- Counters:
  - `cycle_cnt` +1 on every edge while `busy`.
  - `stall_cnt` +1 on every edge with `hazard`=1.
  - Both saturate at all-ones and hold their value in DONE.
- `reset` mid-operation overrides everything: IDLE and reset values on the next edge, with no drain.

## Timing
- Hazard and branch controls are combinational from the EX/ID inputs plus registered state: 0-cycle latency.
- State, `drn` and counters are registered: 1-edge latency.
- Start: `valid` sampled at edge N → `pc_en`=1 from cycle N+1.
- A load-use stall lasts exactly 1 cycle for one load; `lu` naturally clears once the load reaches MEM.
- Finish:
  - `opr_finished` at edge N with no hazard and no branch → DRAIN during cycles N+1..N+DRAIN_CYCLES.
  - `done`=1 from cycle N+DRAIN_CYCLES+1, plus 1 for each drain stall.
- Simultaneous branch and `lu`: the branch wins and `stall_cnt` does not increment.

## Structure
- Shared package (alongside `D_SIZE`/`ADDR_LINE_REG`): enum `pipe_state_t` {IDLE, RUN, DRAIN, DONE} and constant `DRAIN_CYCLES`.
- One sub-module `hazard_detect` holds the combinational `lu` compare.
- FSM, drain counter and perf counters live in `pipe_ctrl`.
- `hazard` connects to the fetch stage's `hazard` input.

## Test plan
- Reset held 3 cycles mid-RUN, with `cycle_cnt`=7 → next cycle IDLE, `pc_en`=0, both flushes 1, counters 0.
- `valid` pulse, 5 clean cycles, then `opr_finished` → `busy` for 5+1+4 cycles, `done`=1, `cycle_cnt`=10, `stall_cnt`=0.
- `ex_mem_read`=1, `ex_rd_addr`=5, `id_rt_addr`=5, `id_uses_rt`=1 for one cycle → `hazard`=1, `pc_en`=0, `id_ex_flush`=1, `stall_cnt`=1.
  - Same with `ex_rd_addr`=0 → no stall.
- `ex_branch_taken` and `lu` in the same cycle → both flushes 1, `pc_en`=1, `hazard`=0, `stall_cnt` unchanged.
- `ex_branch_taken` on drain cycle 2 → state RUN, `pc_en`=1.
  - A later `opr_finished` drains a full 4 cycles.
- `lu` on drain cycle 1 → `drn` holds; `done` asserts 1 cycle later than the nominal 4-cycle drain.
